hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Forwarding and load-use hazard controller for the 5-stage pipeline; sequences the EX stage operand muxes (rs_fwd/rt_fwd) and stalls IF/ID when a result is not yet available.
- Sits beside ID/EX; tracks destination register and opcode of the instructions in EX and MEM (shadow scoreboard).
- Registers forwarding selects so they arrive aligned with the instruction entering EX.

Parameters:
- OP_LDW, 6'h23, load-word opcode (must match def.v LDW)
- OP_SDW, 6'h2B, store-word opcode (must match def.v SDW)
- OP_NOP, 6'h00, opcode injected as bubble; non-writing, non-reading
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  6  opcode of instruction in ID
- id_rs  in  5  source register rs of ID instruction
- id_rt  in  5  source register rt of ID instruction
- id_rwd  in  5  destination register of ID instruction
- freeze  in  1  global pipeline freeze (memory wait); holds all state
- stall  out  1  combinational; hold PC and IF/ID, squash ID->EX this cycle
- rs_fwd  out  3  registered EX alu_a select: 0 regfile, 1 EX/MEM alu result, 2 MEM/WB alu result, 3 MEM/WB load data
- rt_fwd  out  3  registered EX alu_b select, same encoding; 0 for LDW/SDW (immediate path)
- sd_fwd  out  3  registered store-data select for SDW, same encoding; 0 otherwise
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Writer: valid, rwd != 0, opcode not OP_SDW/OP_NOP. Internal ex_rwd/ex_op and mem_rwd/mem_op shadow EX and MEM stages.
- Reads: OP_NOP reads none; OP_LDW reads rs only; OP_SDW reads rs (ALU) and rt (store data); all others read rs and rt (ALU).
- Register 0 never matches; never forwarded, never stalls.
- match1(r): r != 0 and r == ex_rwd (EX is writer). match2(r): r != 0 and r == mem_rwd (MEM is writer).
- stall = id_valid & !rst & ex_op == OP_LDW & (match1 on any register ID reads). Combinational, same cycle.
- Select per read register: match1 -> 1; else match2 & mem_op == OP_LDW -> 3; else match2 -> 2; else 0. Distance 1 has priority over distance 2.
- On posedge clk, rst=1: rs_fwd=rt_fwd=sd_fwd=0, stall_cnt=0, ex_rwd=mem_rwd=0, ex_op=mem_op=OP_NOP. Reset mid-stall clears the pending hazard; stall is low in the reset cycle.
- On posedge clk, freeze=1 (rst=0): no state changes, stall_cnt not incremented. stall still evaluates from held state.
- Normal edge: mem_* <= ex_*. If stall or !id_valid, ex_* <= (0, OP_NOP) and all fwd outputs <= 0 (bubble). Otherwise ex_* <= (id_rwd, id_opcode) and fwd outputs <= computed selects.
- Latency: selects valid in EX one cycle after ID evaluation.
- Load-use: exactly one stall cycle. The following cycle the load is in MEM and the dependent operand gets code 3.
- stall_cnt increments on each non-frozen edge with stall=1. It saturates at all-ones and does not wrap.
- Two consecutive writers to the same register: the younger (EX) wins.

Test Plan:
- Reset, then ADD r3=r1+r2 followed by SUB r4=r3-r5 -> SUB in EX has rs_fwd=1, rt_fwd=0, stall never high.
- ADD r3, unrelated instruction, then OR r6=r5|r3 -> OR in EX has rt_fwd=2, rs_fwd=0.
- LDW r7 then ADD r8=r7+r7 -> stall=1 for exactly 1 cycle, bubble in EX, then ADD in EX with rs_fwd=3, rt_fwd=3, stall_cnt=1.
- ADD r9, then SDW rt=r9 base rs=r2 -> SDW in EX has sd_fwd=1, rt_fwd=0, rs_fwd=0; also ADD r0 then a consumer of r0 -> all selects 0, no stall.
- LDW r7 then ADD using r7, with freeze=1 held 3 cycles during the stall -> stall stays 1, stall_cnt stays 0 until freeze drops, then increments to 1; assert rst during a stall -> stall=0, all outputs 0 on the next edge.
- Preload stall_cnt at 16'hFFFF via repeated load-use pairs -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding-select and load-use stall controller for the 5-stage pipeline.
// Shadows the destination/opcode of the EX and MEM instructions and registers the EX operand selects.
module hazard_fwd_ctrl #(
  parameter logic [5:0] OP_LDW = 6'h23,
  parameter logic [5:0] OP_SDW = 6'h2B,
  parameter logic [5:0] OP_NOP = 6'h00,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rwd,
  input  logic             freeze,
  output logic             stall,
  output logic [2:0]       rs_fwd,
  output logic [2:0]       rt_fwd,
  output logic [2:0]       sd_fwd,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] SEL_RF     = 3'd0;
  localparam logic [2:0] SEL_EXMEM  = 3'd1;
  localparam logic [2:0] SEL_MEMWB  = 3'd2;
  localparam logic [2:0] SEL_MEMLD  = 3'd3;

  // Shadow scoreboard: EX (distance 1) and MEM (distance 2) instructions
  logic [4:0] ex_rwd, mem_rwd;
  logic [5:0] ex_op, mem_op;

  logic       ex_wr, mem_wr, mem_is_ld;
  logic       rd_rs, rd_rt_alu, rd_sd;
  logic       m1_rs, m1_rt, m2_rs, m2_rt;
  logic [2:0] rs_sel, rt_sel, sd_sel;

  function automatic logic is_writer(input logic [5:0] op, input logic [4:0] rwd);
    return (rwd != 5'd0) && (op != OP_SDW) && (op != OP_NOP);
  endfunction

  function automatic logic [2:0] fwd_sel(input logic m1, input logic m2, input logic ld2);
    if (m1)
      return SEL_EXMEM;
    else if (m2 && ld2)
      return SEL_MEMLD;
    else if (m2)
      return SEL_MEMWB;
    else
      return SEL_RF;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // ID stage: operand usage, distance matches, hazard and next selects
  always_comb begin
    ex_wr     = is_writer(ex_op, ex_rwd);
    mem_wr    = is_writer(mem_op, mem_rwd);
    mem_is_ld = (mem_op == OP_LDW);

    rd_rs     = (id_opcode != OP_NOP);
    rd_rt_alu = (id_opcode != OP_NOP) && (id_opcode != OP_LDW) && (id_opcode != OP_SDW);
    rd_sd     = (id_opcode == OP_SDW);

    m1_rs = (id_rs != 5'd0) && ex_wr  && (id_rs == ex_rwd);
    m1_rt = (id_rt != 5'd0) && ex_wr  && (id_rt == ex_rwd);
    m2_rs = (id_rs != 5'd0) && mem_wr && (id_rs == mem_rwd);
    m2_rt = (id_rt != 5'd0) && mem_wr && (id_rt == mem_rwd);

    rs_sel = rd_rs     ? fwd_sel(m1_rs, m2_rs, mem_is_ld) : SEL_RF;
    rt_sel = rd_rt_alu ? fwd_sel(m1_rt, m2_rt, mem_is_ld) : SEL_RF;
    sd_sel = rd_sd     ? fwd_sel(m1_rt, m2_rt, mem_is_ld) : SEL_RF;

    // A load still in EX has no data yet: any distance-1 dependency must wait one cycle
    stall = id_valid && !rst && (ex_op == OP_LDW) &&
            ((rd_rs && m1_rs) || ((rd_rt_alu || rd_sd) && m1_rt));
  end

  // ID/EX boundary: advance scoreboard, register selects or inject a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rwd    <= 5'd0;
      ex_op     <= OP_NOP;
      mem_rwd   <= 5'd0;
      mem_op    <= OP_NOP;
      rs_fwd    <= SEL_RF;
      rt_fwd    <= SEL_RF;
      sd_fwd    <= SEL_RF;
      stall_cnt <= '0;
    end else if (!freeze) begin
      mem_rwd <= ex_rwd;
      mem_op  <= ex_op;
      if (stall || !id_valid) begin
        ex_rwd <= 5'd0;
        ex_op  <= OP_NOP;
        rs_fwd <= SEL_RF;
        rt_fwd <= SEL_RF;
        sd_fwd <= SEL_RF;
      end else begin
        ex_rwd <= id_rwd;
        ex_op  <= id_opcode;
        rs_fwd <= rs_sel;
        rt_fwd <= rt_sel;
        sd_fwd <= sd_sel;
      end
      if (stall)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: directed instruction streams with hand-derived selects.
// A second instance with a 4-bit counter exercises counter saturation within a short run.
module tb_hazard_fwd_ctrl;

  localparam logic [5:0] LDW = 6'h23;
  localparam logic [5:0] SDW = 6'h2B;
  localparam logic [5:0] NOP = 6'h00;
  localparam logic [5:0] ADD = 6'h20;
  localparam logic [5:0] SUB = 6'h22;
  localparam logic [5:0] AND = 6'h24;
  localparam logic [5:0] OR  = 6'h25;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, id_rwd;
  logic        freeze;
  logic        stall;
  logic [2:0]  rs_fwd, rt_fwd, sd_fwd;
  logic [15:0] stall_cnt;

  logic        stall4;
  logic [2:0]  rs_fwd4, rt_fwd4, sd_fwd4;
  logic [3:0]  stall_cnt4;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;
  int exp_cnt4 = 0;

  typedef struct {
    string      tag;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] sd;
    int         cnt;
    int         cnt4;
  } exp_t;

  exp_t sb[$];

  hazard_fwd_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rwd(id_rwd), .freeze(freeze),
    .stall(stall), .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .sd_fwd(sd_fwd),
    .stall_cnt(stall_cnt)
  );

  hazard_fwd_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rwd(id_rwd), .freeze(freeze),
    .stall(stall4), .rs_fwd(rs_fwd4), .rt_fwd(rt_fwd4), .sd_fwd(sd_fwd4),
    .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Registered outputs are compared 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_rs"},   int'(rs_fwd),     int'(e.rs));
      chk({e.tag, "_rt"},   int'(rt_fwd),     int'(e.rt));
      chk({e.tag, "_sd"},   int'(sd_fwd),     int'(e.sd));
      chk({e.tag, "_cnt"},  int'(stall_cnt),  e.cnt);
      chk({e.tag, "_cnt4"}, int'(stall_cnt4), e.cnt4);
    end
  end

  // Called at posedge+1: drives ID, checks combinational stall, queues post-edge expectations
  task automatic step(input string tag, input bit r, input bit f, input bit v,
                      input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input bit exp_stall,
                      input logic [2:0] ers, input logic [2:0] ert, input logic [2:0] esd);
    exp_t e;
    rst = r; freeze = f; id_valid = v; id_opcode = op;
    id_rs = rs; id_rt = rt; id_rwd = rd;
    #3;
    chk({tag, "_stall"}, int'(stall), int'(exp_stall));
    if (r) begin
      exp_cnt = 0;
      exp_cnt4 = 0;
    end else if (!f && exp_stall) begin
      if (exp_cnt < 16'hFFFF) exp_cnt++;
      if (exp_cnt4 < 15) exp_cnt4++;
    end
    e.tag = tag; e.rs = ers; e.rt = ert; e.sd = esd;
    e.cnt = exp_cnt; e.cnt4 = exp_cnt4;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; id_valid = 1'b0; id_opcode = NOP;
    id_rs = '0; id_rt = '0; id_rwd = '0;
    @(posedge clk);
    #1;
    sb.delete();

    //                r  f  v  op   rs  rt  rd  stl rs rt sd
    step("reset",     1, 0, 0, NOP, 0,  0,  0,  0,  0, 0, 0);
    // distance-1 ALU dependency
    step("add_r3",    0, 0, 1, ADD, 1,  2,  3,  0,  0, 0, 0);
    step("sub_r3",    0, 0, 1, SUB, 3,  5,  4,  0,  1, 0, 0);
    // distance-2 ALU dependency on rt
    step("add_r3b",   0, 0, 1, ADD, 1,  2,  3,  0,  0, 0, 0);
    step("and_unrel", 0, 0, 1, AND, 11, 12, 10, 0,  0, 0, 0);
    step("or_r3",     0, 0, 1, OR,  5,  3,  6,  0,  0, 2, 0);
    // load-use: one stall cycle, then load data from MEM/WB
    step("ldw_r7",    0, 0, 1, LDW, 1,  7,  7,  0,  0, 0, 0);
    step("lu_stall",  0, 0, 1, ADD, 7,  7,  8,  1,  0, 0, 0);
    step("lu_fwd",    0, 0, 1, ADD, 7,  7,  8,  0,  3, 3, 0);
    // store data forwarding and register zero
    step("add_r9",    0, 0, 1, ADD, 1,  2,  9,  0,  0, 0, 0);
    step("sdw_r9",    0, 0, 1, SDW, 2,  9,  0,  0,  0, 0, 1);
    step("add_r0",    0, 0, 1, ADD, 1,  2,  0,  0,  0, 0, 0);
    step("use_r0",    0, 0, 1, OR,  0,  0,  11, 0,  0, 0, 0);
    // younger writer wins
    step("add_r12a",  0, 0, 1, ADD, 1,  2,  12, 0,  0, 0, 0);
    step("add_r12b",  0, 0, 1, ADD, 2,  1,  12, 0,  0, 0, 0);
    step("sub_r12",   0, 0, 1, SUB, 12, 12, 13, 0,  1, 1, 0);
    // freeze during a load-use stall holds selects and counter
    step("bub0",      0, 0, 0, NOP, 0,  0,  0,  0,  0, 0, 0);
    step("bub1",      0, 0, 0, NOP, 0,  0,  0,  0,  0, 0, 0);
    step("add_r1",    0, 0, 1, ADD, 2,  3,  1,  0,  0, 0, 0);
    step("ldw_fz",    0, 0, 1, LDW, 1,  7,  7,  0,  1, 0, 0);
    for (int i = 0; i < 3; i++)
      step("frz_hold",0, 1, 1, ADD, 7,  7,  8,  1,  1, 0, 0);
    step("frz_rel",   0, 0, 1, ADD, 7,  7,  8,  1,  0, 0, 0);
    step("frz_fwd",   0, 0, 1, ADD, 7,  7,  8,  0,  3, 3, 0);
    // reset in the middle of a load-use stall
    step("ldw_rs",    0, 0, 1, LDW, 0,  7,  7,  0,  0, 0, 0);
    step("rs_stall",  0, 0, 1, ADD, 7,  7,  8,  1,  0, 0, 0);
    step("rs_mid",    1, 0, 1, ADD, 7,  7,  8,  0,  0, 0, 0);
    step("rs_after",  0, 0, 1, ADD, 7,  7,  8,  0,  0, 0, 0);
    // repeated load-use pairs saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      step("sat_ldw", 0, 0, 1, LDW, 0,  7,  7,  0,  0, 0, 0);
      step("sat_stl", 0, 0, 1, ADD, 7,  7,  8,  1,  0, 0, 0);
      step("sat_fwd", 0, 0, 1, ADD, 7,  7,  8,  0,  3, 3, 0);
    end
    step("idle",      0, 0, 0, NOP, 0,  0,  0,  0,  0, 0, 0);
    #2;
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
